// File: rtl/telem_serializer.sv
// telem_serializer: assembles the serial telemetry word, prefixes its tag,
// appends odd parity and shifts the resulting frame out on the PCM link.
// The word path is double-buffered: assembly register, holding buffer and
// output shifter. When no word is waiting, a fill frame is sent instead.
module telem_serializer #(
  parameter int WORD_BITS = 26,
  parameter int TAG_BITS  = 9
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic                TCW,
  input  logic                DIN,
  input  logic                DSTB,
  input  logic                TRP,
  input  logic [TAG_BITS-1:0] TAG,
  input  logic                PCMSYN,
  input  logic                PCMSTB,
  input  logic                FLGC,
  output logic                TLMD,
  output logic                TBUSY,
  output logic                TFULL,
  output logic                TFILL,
  output logic                TOVR,
  output logic                TERR
);

  localparam int F      = TAG_BITS + WORD_BITS + 1;
  localparam int BCNT_W = $clog2(WORD_BITS + 2);
  localparam int CNT_W  = $clog2(F + 1);

  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(WORD_BITS);
  localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(WORD_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(F);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
  // Fill frame: zero tag, zero data, and the odd-parity bit that makes it legal.
  localparam logic [F-1:0]      FILL_WORD = F'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [WORD_BITS-1:0] asm_reg;
  logic [BCNT_W-1:0]    bcnt;
  logic [F-1:0]         hold_reg;
  logic                 tfull;
  logic                 tfill;
  logic                 tovr;
  logic                 terr;

  state_t               state;
  state_t               state_next;
  logic [F-2:0]         shifter;
  logic [F-2:0]         shifter_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 tlmd;
  logic                 tlmd_next;
  logic                 tfill_next;

  logic                 trp_ok;
  logic                 load;
  logic                 parity;
  logic [F-1:0]         frame_src;

  // A transfer is only legal when exactly one full word has been assembled;
  // a frame is only loaded from IDLE, so PCMSYN during a frame is ignored.
  assign trp_ok    = TRP && (bcnt == BCNT_FULL);
  assign load      = (state == IDLE) && PCMSYN;
  assign parity    = ~^{TAG, asm_reg};
  assign frame_src = tfull ? hold_reg : FILL_WORD;

  // Assembly register: TRP and a closed window both restart the count; a bit
  // strobe coinciding with TRP is deliberately lost.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      asm_reg <= '0;
      bcnt    <= '0;
    end else if (TRP || !TCW) begin
      bcnt <= '0;
    end else if (DSTB) begin
      asm_reg <= {asm_reg[WORD_BITS-2:0], DIN};
      if (bcnt != BCNT_SAT) begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Holding buffer: a new word always wins over the frame load that empties it.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      hold_reg <= '0;
      tfull    <= 1'b0;
    end else begin
      if (trp_ok) begin
        hold_reg <= {TAG, asm_reg, parity};
        tfull    <= 1'b1;
      end else if (load) begin
        tfull <= 1'b0;
      end
    end
  end

  // Sticky error flags: a new set event beats a same-cycle clear.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      tovr <= 1'b0;
      terr <= 1'b0;
    end else begin
      if (trp_ok && tfull && !load) begin
        tovr <= 1'b1;
      end else if (FLGC) begin
        tovr <= 1'b0;
      end
      if (TRP && !trp_ok) begin
        terr <= 1'b1;
      end else if (FLGC) begin
        terr <= 1'b0;
      end
    end
  end

  // Output FSM state register together with the shifter it controls.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= IDLE;
      shifter <= '0;
      cnt     <= '0;
      tlmd    <= 1'b0;
      tfill   <= 1'b0;
    end else begin
      state   <= state_next;
      shifter <= shifter_next;
      cnt     <= cnt_next;
      tlmd    <= tlmd_next;
      tfill   <= tfill_next;
    end
  end

  // Output FSM next-state: the frame MSB goes straight into the TLMD register
  // on load, the shifter holds the bits still to come.
  always_comb begin
    state_next   = state;
    shifter_next = shifter;
    cnt_next     = cnt;
    tlmd_next    = tlmd;
    tfill_next   = tfill;
    case (state)
      IDLE: begin
        if (PCMSYN) begin
          shifter_next = frame_src[F-2:0];
          tlmd_next    = frame_src[F-1];
          tfill_next   = !tfull;
          cnt_next     = CNT_LOAD;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (PCMSTB) begin
          cnt_next = cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            tlmd_next  = 1'b0;
            state_next = IDLE;
          end else begin
            tlmd_next    = shifter[F-2];
            shifter_next = {shifter[F-3:0], 1'b0};
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign TLMD  = tlmd;
  assign TBUSY = (state == SHIFT);
  assign TFULL = tfull;
  assign TFILL = tfill;
  assign TOVR  = tovr;
  assign TERR  = terr;

endmodule

// File: doc/telem_serializer.md
Name: telem_serializer

Overview:
- Downstream stage of the LVDA telemetry control logic: assembles the serial telemetry word delivered on DIN, tags it, adds odd parity and serializes it to the PCM telemetry link.
- Double-buffered: assembly register (computer side), holding buffer, output shifter (PCM side).
- Flags overrun, short/long words and fill-word insertion for the PCM system.

Parameters:
- WORD_BITS, 26, data bits per telemetry word.
- TAG_BITS, 9, tag/address bits prefixed to each word.
- Derived, not overridable: F = TAG_BITS + WORD_BITS + 1 (frame bits, default 36).

Ports:
- SIM_CLK  in  1  single system clock.
- SIM_RST  in  1  asynchronous, active-high reset.
- TCW  in  1  assembly window; low clears the bit count.
- DIN  in  1  serial data bit from the telemetry control stage.
- DSTB  in  1  one-cycle bit strobe; samples DIN.
- TRP  in  1  one-cycle telemetry register pulse; transfers the assembled word to the holding buffer.
- TAG  in  TAG_BITS  tag captured at TRP.
- PCMSYN  in  1  one-cycle PCM word-sync strobe; starts a frame.
- PCMSTB  in  1  one-cycle PCM bit strobe.
- FLGC  in  1  one-cycle flag clear.
- TLMD  out  1  serial PCM data, registered.
- TBUSY  out  1  frame in progress.
- TFULL  out  1  holding buffer occupied.
- TFILL  out  1  current or last frame was a fill word.
- TOVR  out  1  sticky overrun.
- TERR  out  1  sticky word-length error.

Behaviour:
- All inputs are synchronous to SIM_CLK; all strobes are single-cycle.
- Reset (async, active-high): all registers 0. Outputs TLMD=0, TBUSY=0, TFULL=0, TFILL=0, TOVR=0, TERR=0. Reset mid-frame aborts the frame immediately.
- Assembly: DSTB with TCW=1 shifts DIN into the LSB of asm_reg (MSB-first arrival) and increments bcnt, saturating at WORD_BITS+1. TCW=0 forces bcnt to 0; asm_reg is retained.
- TRP with bcnt==WORD_BITS: hold_reg <= {TAG, asm_reg, p}, where p = odd parity over TAG and asm_reg (XNOR reduction). Then TFULL <= 1, bcnt <= 0.
- TRP with bcnt!=WORD_BITS: no transfer, TERR <= 1, bcnt <= 0.
- TRP and DSTB in the same cycle: TRP uses the pre-cycle bcnt; that DSTB is dropped.
- TRP while TFULL=1 and no frame load in the same cycle: hold_reg is overwritten and TOVR <= 1.
- Output FSM states: IDLE, SHIFT.
- IDLE + PCMSYN:
  - If TFULL: shifter <= hold_reg, TFULL cleared, TFILL <= 0.
  - Otherwise: shifter <= fill word {0, 0, 1}, TFILL <= 1.
  - In both cases: cnt <= F, go to SHIFT, TBUSY=1. TLMD = frame MSB from the next cycle.
- SHIFT + PCMSTB: cnt decrements. If cnt becomes 0, go to IDLE, TBUSY=0, TLMD=0. Otherwise the shifter shifts left and TLMD shows the next bit the following cycle. Total: F bits over F-1 strobes, ended by the F-th strobe.
- PCMSYN in SHIFT: ignored.
- PCMSTB in IDLE: ignored.
- Same-cycle TRP and PCMSYN:
  - Load decision uses the pre-cycle TFULL.
  - If TFULL=1: old hold_reg goes out, the new word lands in hold_reg, TFULL stays 1, no overrun.
  - If TFULL=0: fill word goes out and the new word lands in hold_reg (TFULL=1).
- FLGC clears TOVR and TERR. A set in the same cycle as FLGC wins.
- Latency:
  - DSTB to bit captured: 1 cycle.
  - TRP to TFULL: 1 cycle.
  - PCMSYN to first TLMD bit: 1 cycle.
  - PCMSTB to next bit: 1 cycle.

Test Plan:
- Normal word: TCW=1, 26 DSTB with data 26'h0000001, TRP with TAG=9'h1A5, PCMSYN, 35 PCMSTB -> TLMD sequence 1,1,0,1,0,0,1,0,1, then 25×0, then 1, then parity 1. TBUSY high for exactly 36 bit times. TFULL 1→0 at PCMSYN. TFILL=0.
- Fill: PCMSYN with TFULL=0 -> 35×0 then 1. TFILL=1. TBUSY drops on the 36th PCMSTB.
- Short/long word: 25 DSTB then TRP -> TERR=1, TFULL stays 0. Repeat with 27 DSTB -> TERR=1. FLGC -> TERR=0.
- Overrun: two valid TRPs with no PCMSYN between -> TOVR=1, second word transmitted on the next frame. Valid TRP and PCMSYN in the same cycle with TFULL=1 -> TOVR stays 0, both words sent in order.
- Collisions: TRP+DSTB in the same cycle -> DSTB bit dropped, bcnt=0. PCMSYN mid-frame -> frame is unaltered.
- Async reset mid-frame (bit 10) -> TLMD=0 and TBUSY=0 immediately. All flags 0. The next PCMSYN emits a fill word.
